// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//   Fetch stage of the five-stage MIPS pipeline. It owns the program counter
//   and the IF/ID pipeline register, and it keeps saturating performance
//   counters for stall cycles and branch redirects.
//
// Parameters
//   RESET_PC   PC value loaded on reset
//   CNT_WIDTH  width of each event counter
//
// Ports
//   Clk, Reset          clock; synchronous active-high reset
//   PCWrite             1 = PC advances, 0 = PC holds (load-use stall)
//   IF_ID_Write         1 = IF/ID loads, 0 = IF/ID holds
//   BranchTaken         redirect the PC and flush IF/ID
//   BranchTarget        redirect address; low two bits are forced to zero
//   InstrMem_Addr       instruction memory address (the current PC)
//   InstrMem_Data       instruction word, read combinationally from memory
//   IF_ID_Instruction   registered instruction for decode
//   IF_ID_PCPlus4       registered PC+4 of that instruction
//   IF_ID_Valid         1 = real instruction, 0 = bubble
//   StallCount          saturating count of stalled cycles
//   FlushCount          saturating count of redirects
// ---------------------------------------------------------------------------

// Saturating event counter. It clears on reset and stops at all-ones.
module ifs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end
endmodule

module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 PCWrite,
  input  logic                 IF_ID_Write,
  input  logic                 BranchTaken,
  input  logic [31:0]          BranchTarget,
  output logic [31:0]          InstrMem_Addr,
  input  logic [31:0]          InstrMem_Data,
  output logic [31:0]          IF_ID_Instruction,
  output logic [31:0]          IF_ID_PCPlus4,
  output logic                 IF_ID_Valid,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        stall_evt;
  logic        flush_evt;

  // The sum is taken modulo 2^32, so 0xFFFF_FFFC wraps to 0.
  assign pc_plus4      = pc + 32'd4;
  assign target        = BranchTarget & 32'hFFFF_FFFC;
  assign InstrMem_Addr = pc;

  // A redirect overrides a stall. It counts as a flush only, never as a
  // stall, so one cycle cannot raise both counters.
  assign flush_evt = BranchTaken;
  assign stall_evt = !BranchTaken && !PCWrite;

  // PC register
  always_ff @(posedge Clk) begin
    if (Reset)
      pc <= RESET_PC;
    else if (BranchTaken)
      pc <= target;
    else if (PCWrite)
      pc <= pc_plus4;
  end

  // IF/ID register. A flush inserts a nop bubble even when IF_ID_Write=0.
  always_ff @(posedge Clk) begin
    if (Reset || BranchTaken) begin
      IF_ID_Instruction <= 32'h0000_0000;
      IF_ID_PCPlus4     <= 32'h0000_0000;
      IF_ID_Valid       <= 1'b0;
    end else if (IF_ID_Write) begin
      IF_ID_Instruction <= InstrMem_Data;
      IF_ID_PCPlus4     <= pc_plus4;
      IF_ID_Valid       <= 1'b1;
    end
  end

  ifs_sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .inc   (stall_evt),
    .count (StallCount)
  );

  ifs_sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .inc   (flush_evt),
    .count (FlushCount)
  );

endmodule
